lsf_multi_channel_arbiter: RTL
==============================

// Module: lsf_multi_channel_arbiter
// PURPOSE
//  Parametrised N-channel input stage for the Legendre segment finder (LSF). Each channel has its
//  own ROI FIFO and MDT-hit FIFO. A round-robin event arbiter hands whole events (one ROI, then
//  its hits up to and including the hit flagged last) to a single legendreEngine_top through
//  FIFO-style read ports. Adds per-channel saturating drop counters.
// PARAMETERS
//  NUM_CH     3                    number of input channels (>=1)
//  HIT_W      HPS_LSF_LEN          hit payload width
//  ROI_W      SLCPROC_HPS_SF_LEN   ROI payload width
//  HIT_DEPTH  32                   hit FIFO depth per channel, power of 2
//  ROI_DEPTH  8                    ROI FIFO depth per channel, power of 2
//  AF_MARGIN  4                    almost_full asserts when free entries <= AF_MARGIN
//  CNT_W      16                   drop counter width
// PORTS
//  clock          in   1                  TP clock, nominally 200 MHz
//  reset          in   1                  synchronous, active-low
//  hit_data       in   [NUM_CH][HIT_W]    per-channel hit payload
//  hit_last       in   [NUM_CH]           marks last hit of the event
//  hit_we         in   [NUM_CH]           hit write strobe
//  hit_af         out  [NUM_CH]           hit FIFO almost full
//  roi_data       in   [NUM_CH][ROI_W]    per-channel ROI payload
//  roi_we         in   [NUM_CH]           ROI write strobe
//  roi_af         out  [NUM_CH]           ROI FIFO almost full
//  out_roi        out  ROI_W              granted channel ROI FIFO head
//  out_roi_empty  out  1                  no ROI available to engine
//  out_roi_re     in   1                  engine pops ROI
//  out_hit        out  HIT_W              granted channel hit FIFO head
//  out_hit_last   out  1                  last flag of out_hit
//  out_hit_empty  out  1                  no hit available to engine
//  out_hit_re     in   1                  engine pops hit
//  out_ch         out  $clog2(NUM_CH)     currently granted channel (max(1,..) bits)
//  busy           out  1                  event in progress (state != IDLE)
//  clr_counters   in   1                  zero all drop counters
//  drop_cnt       out  [NUM_CH][CNT_W]    hits+ROIs dropped per channel
// BEHAVIOUR
//  Reset (reset==0 at posedge): all FIFOs flushed, FSM IDLE, rr_ptr=0, out_ch=0, busy=0,
//   out_roi_empty=1, out_hit_empty=1, out_roi/out_hit/out_hit_last=0, af=0, drop_cnt=0.
//   Reset mid-event discards the event; no partial data survives.
//  FIFOs: first-word-fall-through; head valid whenever not empty. Write at posedge, empty
//   deasserts the following cycle. Full sampled at cycle start: write while full is dropped even
//   if a read occurs in the same cycle; drop_cnt[ch] +1 (per ROI or hit dropped), saturating at
//   2^CNT_W-1. clr_counters has priority over a same-cycle increment (result 0).
//  FSM (one-hot or enum):
//   IDLE  : scan ch = rr_ptr, rr_ptr+1, ... mod NUM_CH; first with ROI FIFO non-empty -> latch
//           out_ch, go ROI. None -> stay. Both output empties = 1.
//   ROI   : out_roi_empty = 0, out_hit_empty = 1. On out_roi_re -> pop ROI, go HITS.
//   HITS  : out_hit_empty = hit FIFO[out_ch] empty, out_roi_empty = 1. On out_hit_re & !empty:
//           pop; if head.last -> rr_ptr = (out_ch+1) mod NUM_CH, go IDLE.
//  Reads while the corresponding output is empty are ignored (no pop, no state change).
//  Latency: ROI written cycle 0 -> out_roi_empty=0 at cycle 2 when FSM idle. IDLE->ROI costs
//   1 cycle between events. Hits of one channel never interleave with another's.
//  Upstream contract: every ROI is followed by >=1 hit, final one with hit_last=1; hits may
//   arrive before or after their ROI. A missing last hit stalls the arbiter (no timeout).
//  NUM_CH=1: rr_ptr stays 0; behaviour otherwise identical.
// STRUCTURE
//  lsf_arb_pkg: state typedef (IDLE/ROI/HITS), CH_W = max(1,$clog2(NUM_CH)), hit-entry struct
//   {last, data}.
//  Sub-module lsf_sync_fifo (WIDTH, DEPTH, AF_MARGIN; FWFT, count-based full/empty/af),
//   instantiated 2*NUM_CH times via generate; hit FIFO width HIT_W+1.
//  Top holds FSM, round-robin pointer, output muxes, drop counters.
// TESTING
//  1 single event ch0: ROI A, hits h1,h2,h3(last) -> engine reads A,h1,h2,h3; out_ch=0; busy
//    returns 0 one cycle after h3 pop.
//  2 ROIs on ch0,1,2 simultaneously, 2 hits each -> events served order 0,1,2; then new ROI on ch0
//    and ch2 with rr_ptr=0 -> order 0,2.
//  3 overflow: 36 hits written to ch1 (HIT_DEPTH=32) without reads -> hit_af high at 28 entries,
//    drop_cnt[1]=4; clr_counters -> 0; drop at 2^16-1 stays saturated.
//  4 hits before ROI: ch2 hits x,y(last) then ROI R 10 cycles later -> out R,x,y; out_hit_empty=1
//    while in ROI state.
//  5 reset pulled low mid-HITS on ch1 after 1 of 3 hits -> all outputs reset values next cycle;
//    afterwards new event on ch1 delivered clean, no stale hits.
//  6 reads asserted while empty (idle and mid-HITS with hit FIFO empty) -> no pop, no state change.

Source files
------------

// File: rtl/lsf_arb_pkg.sv
// Shared types and helpers for the LSF multi-channel input arbiter.
package lsf_arb_pkg;

  localparam int unsigned HPS_LSF_LEN        = 24;
  localparam int unsigned SLCPROC_HPS_SF_LEN = 20;

  typedef enum logic [1:0] {StIdle, StRoi, StHits} arb_state_e;

  typedef struct packed {
    logic                   last;
    logic [HPS_LSF_LEN-1:0] data;
  } hit_entry_t;

  // Channel index width; a single channel still gets one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with count-based empty/almost-full and drop flag.
module lsf_sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             af,
  output logic             dropped
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign af      = (32'(DEPTH) - 32'(count_q)) <= 32'(AF_MARGIN);
  // Full is judged on the start-of-cycle count, so a same-cycle read does not rescue a write.
  assign push    = we & ~full;
  assign pop     = re & ~empty;
  assign dropped = we & full;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lsf_multi_channel_arbiter.sv
// N-channel LSF input stage: per-channel ROI/hit FIFOs, round-robin whole-event arbiter,
// saturating per-channel drop counters.
module lsf_multi_channel_arbiter
  import lsf_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned HIT_W     = HPS_LSF_LEN,
  parameter int unsigned ROI_W     = SLCPROC_HPS_SF_LEN,
  parameter int unsigned HIT_DEPTH = 32,
  parameter int unsigned ROI_DEPTH = 8,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned CH_W     = ch_width(NUM_CH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0][HIT_W-1:0]  hit_data,
  input  logic [NUM_CH-1:0]             hit_last,
  input  logic [NUM_CH-1:0]             hit_we,
  output logic [NUM_CH-1:0]             hit_af,
  input  logic [NUM_CH-1:0][ROI_W-1:0]  roi_data,
  input  logic [NUM_CH-1:0]             roi_we,
  output logic [NUM_CH-1:0]             roi_af,
  output logic [ROI_W-1:0]              out_roi,
  output logic                          out_roi_empty,
  input  logic                          out_roi_re,
  output logic [HIT_W-1:0]              out_hit,
  output logic                          out_hit_last,
  output logic                          out_hit_empty,
  input  logic                          out_hit_re,
  output logic [CH_W-1:0]               out_ch,
  output logic                          busy,
  input  logic                          clr_counters,
  output logic [NUM_CH-1:0][CNT_W-1:0]  drop_cnt
);

  typedef struct packed {
    logic             last;
    logic [HIT_W-1:0] data;
  } hit_word_t;

  hit_word_t [NUM_CH-1:0]            hit_head;
  logic [NUM_CH-1:0][ROI_W-1:0]      roi_head;
  logic [NUM_CH-1:0]                 hit_empty, roi_empty;
  logic [NUM_CH-1:0]                 hit_pop, roi_pop;
  logic [NUM_CH-1:0]                 hit_drop, roi_drop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lsf_sync_fifo #(
      .WIDTH     (HIT_W + 1),
      .DEPTH     (HIT_DEPTH),
      .AF_MARGIN (AF_MARGIN)
    ) u_hit_fifo (
      .clock   (clock),
      .reset   (reset),
      .wdata   ({hit_last[g], hit_data[g]}),
      .we      (hit_we[g]),
      .re      (hit_pop[g]),
      .rdata   (hit_head[g]),
      .empty   (hit_empty[g]),
      .af      (hit_af[g]),
      .dropped (hit_drop[g])
    );

    lsf_sync_fifo #(
      .WIDTH     (ROI_W),
      .DEPTH     (ROI_DEPTH),
      .AF_MARGIN (AF_MARGIN)
    ) u_roi_fifo (
      .clock   (clock),
      .reset   (reset),
      .wdata   (roi_data[g]),
      .we      (roi_we[g]),
      .re      (roi_pop[g]),
      .rdata   (roi_head[g]),
      .empty   (roi_empty[g]),
      .af      (roi_af[g]),
      .dropped (roi_drop[g])
    );
  end

  arb_state_e                   state_q, state_d;
  logic [CH_W-1:0]              out_ch_q, out_ch_d, rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]              scan_sel, next_ch;
  logic                         scan_found;
  logic [NUM_CH-1:0][CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  hit_word_t                    cur_hit;
  logic                         cur_hit_empty, cur_roi_empty;

  assign cur_hit       = hit_head[out_ch_q];
  assign cur_hit_empty = hit_empty[out_ch_q];
  assign cur_roi_empty = roi_empty[out_ch_q];
  assign next_ch       = (out_ch_q == CH_W'(NUM_CH - 1)) ? '0 : out_ch_q + 1'b1;

  // Round-robin scan starting at rr_ptr, first non-empty ROI FIFO wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_sel   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!scan_found && !roi_empty[CH_W'(idx)]) begin
        scan_found = 1'b1;
        scan_sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    rr_ptr_d = rr_ptr_q;
    roi_pop  = '0;
    hit_pop  = '0;
    unique case (state_q)
      StIdle: begin
        if (scan_found) begin
          out_ch_d = scan_sel;
          state_d  = StRoi;
        end
      end
      StRoi: begin
        if (out_roi_re && !cur_roi_empty) begin
          roi_pop[out_ch_q] = 1'b1;
          state_d           = StHits;
        end
      end
      StHits: begin
        if (out_hit_re && !cur_hit_empty) begin
          hit_pop[out_ch_q] = 1'b1;
          if (cur_hit.last) begin
            rr_ptr_d = next_ch;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_roi_empty = (state_q != StRoi) | cur_roi_empty;
  assign out_hit_empty = (state_q != StHits) | cur_hit_empty;
  assign out_roi       = out_roi_empty ? '0 : roi_head[out_ch_q];
  assign out_hit       = out_hit_empty ? '0 : cur_hit.data;
  assign out_hit_last  = out_hit_empty ? 1'b0 : cur_hit.last;
  assign out_ch        = out_ch_q;
  assign busy          = (state_q != StIdle);
  assign drop_cnt      = drop_cnt_q;

  // A channel can lose a hit and an ROI in the same cycle, so the increment is 0..2.
  always_comb begin
    logic [CNT_W:0] sum;
    sum        = '0;
    drop_cnt_d = drop_cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, drop_cnt_q[i]} + (CNT_W+1)'(hit_drop[i]) + (CNT_W+1)'(roi_drop[i]);
      if (clr_counters)  drop_cnt_d[i] = '0;
      else if (sum[CNT_W]) drop_cnt_d[i] = '1;
      else               drop_cnt_d[i] = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_ch_q   <= out_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
